// File: rtl/draw_rect_pkg.sv
// Shared definitions for the falling-rectangle controller: state encoding,
// geometry helpers and the saturating velocity add.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        RISE   = 2'd2,
        REST   = 2'd3
    } phys_state_t;

    function automatic int floor_of(input int screen_h, input int rect_h);
        return screen_h - rect_h;
    endfunction

    function automatic int xmax_of(input int screen_w, input int rect_w);
        return screen_w - rect_w;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Physics tick divider: down-counter with terminal-count compare, restartable.
module tick_gen #(
    parameter int TICK_DIV = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int            CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // a restart cycle never counts as a tick, so re-grab always wins
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/draw_rect_phys_ctl.sv
// Rectangle position controller: follows the mouse, drops under gravity on click,
// bounces off the floor and rests. Optional horizontal drift: DRAW_RECT_PHYS_HDRIFT_EN.
//
// state  | meaning
// FOLLOW | rectangle tracks the clamped mouse position
// FALL   | accelerating downward once per tick
// RISE   | decelerating upward after a floor bounce
// REST   | settled on the floor, positions hold
module draw_rect_phys_ctl
    import draw_rect_pkg::*;
#(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int RECT_W       = 48,
    parameter int RECT_H       = 64,
    parameter int FRAC_BITS    = 4,
    parameter int VEL_W        = 16,
    parameter int GRAVITY      = 16,
    parameter int BOUNCE_SHIFT = 1,
    parameter int V_REST       = 16,
    parameter int TICK_DIV     = 65000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mouse_left,
    input  logic [11:0] mouse_x_position,
    input  logic [11:0] mouse_y_position,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  phys_state
);
    localparam logic [1:0] S_FOLLOW = FOLLOW;
    localparam logic [1:0] S_FALL   = FALL;
    localparam logic [1:0] S_RISE   = RISE;
    localparam logic [1:0] S_REST   = REST;

    localparam logic [11:0]      FLOOR12   = 12'(floor_of(SCREEN_H, RECT_H));
    localparam logic [11:0]      XMAX12    = 12'(xmax_of(SCREEN_W, RECT_W));
    localparam logic [31:0]      VEL_MAX32 = 32'((64'd1 << VEL_W) - 64'd1);
    localparam logic [VEL_W-1:0] GRAV_V    = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0] VREST_V   = VEL_W'(V_REST);

    logic [1:0]       state;
    logic [VEL_W-1:0] vel;
    logic             ml_q;
    logic             click;
    logic             tick;
    logic [11:0]      x_clamp;
    logic [11:0]      y_clamp;
    logic [VEL_W-1:0] step;
    logic [VEL_W-1:0] damped;
    logic [VEL_W-1:0] vel_inc;
    logic [31:0]      y_sum;
    logic [11:0]      y_up;
    logic             fall_hit;

    assign click    = mouse_left && !ml_q;
    assign x_clamp  = (mouse_x_position > XMAX12)  ? XMAX12  : mouse_x_position;
    assign y_clamp  = (mouse_y_position > FLOOR12) ? FLOOR12 : mouse_y_position;
    assign step     = vel >> FRAC_BITS;
    assign damped   = vel >> BOUNCE_SHIFT;
    assign vel_inc  = VEL_W'(sat_add(32'(vel), 32'(GRAVITY), VEL_MAX32));
    assign y_sum    = 32'(ypos) + 32'(step);
    assign fall_hit = (y_sum >= 32'(FLOOR12));
    assign y_up     = (32'(step) >= 32'(ypos)) ? 12'd0 : ypos - 12'(step);

    assign phys_state = state;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (click),
        .tick    (tick)
    );

`ifdef DRAW_RECT_PHYS_HDRIFT_EN
    localparam logic signed [13:0] XMAX_S = 14'(XMAX12);

    logic signed [4:0]  hvel;
    logic [11:0]        x_at_tick;
    logic signed [12:0] dx;
    logic signed [4:0]  hvel_cap;
    logic signed [13:0] x_next;
    logic               to_rest;

    assign dx       = $signed({1'b0, mouse_x_position}) - $signed({1'b0, x_at_tick});
    assign hvel_cap = (dx > 13'sd15) ? 5'sd15 : (dx < -13'sd15) ? -5'sd15 : dx[4:0];
    assign x_next   = $signed({2'b00, xpos}) + 14'(hvel);
    assign to_rest  = (state == S_FALL) && fall_hit && (damped < VREST_V);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FOLLOW;
            vel   <= '0;
            ml_q  <= 1'b0;
            xpos  <= '0;
            ypos  <= '0;
`ifdef DRAW_RECT_PHYS_HDRIFT_EN
            hvel      <= '0;
            x_at_tick <= '0;
`endif
        end else begin
            ml_q <= mouse_left;
`ifdef DRAW_RECT_PHYS_HDRIFT_EN
            if (tick) x_at_tick <= mouse_x_position;
`endif
            case (state)
                S_FOLLOW: begin
                    xpos <= x_clamp;
                    ypos <= y_clamp;
                    if (click) begin
                        state <= S_FALL;
                        vel   <= '0;
`ifdef DRAW_RECT_PHYS_HDRIFT_EN
                        hvel  <= hvel_cap;
`endif
                    end
                end
                default: begin
                    if (click) begin
                        state <= S_FOLLOW;
                        vel   <= '0;
`ifdef DRAW_RECT_PHYS_HDRIFT_EN
                        hvel  <= '0;
`endif
                    end else if (tick) begin
                        case (state)
                            S_FALL: begin
                                if (fall_hit) begin
                                    ypos <= FLOOR12;
                                    if (damped < VREST_V) begin
                                        state <= S_REST;
                                        vel   <= '0;
                                    end else begin
                                        state <= S_RISE;
                                        vel   <= damped;
                                    end
                                end else begin
                                    ypos <= y_sum[11:0];
                                    vel  <= vel_inc;
                                end
                            end
                            S_RISE: begin
                                ypos <= y_up;
                                if (vel <= GRAV_V) begin
                                    state <= S_FALL;
                                    vel   <= '0;
                                end else begin
                                    vel <= vel - GRAV_V;
                                end
                            end
                            default: ;
                        endcase
`ifdef DRAW_RECT_PHYS_HDRIFT_EN
                        // touching a wall counts as crossing it: clamp and reflect
                        if (state != S_REST) begin
                            if (x_next <= 14'sd0) begin
                                xpos <= '0;
                                hvel <= -hvel;
                            end else if (x_next >= XMAX_S) begin
                                xpos <= XMAX12;
                                hvel <= -hvel;
                            end else begin
                                xpos <= x_next[11:0];
                            end
                        end
                        if (to_rest) hvel <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect_phys_ctl.sv
// Self-checking bench for draw_rect_phys_ctl (TICK_DIV=4): directed test-plan
// sequences plus randomized mouse activity against a behavioural model.
module tb_draw_rect_phys_ctl;
    localparam int TD    = 4;
    localparam int FLOOR = 600 - 64;
    localparam int XMAX  = 800 - 48;
    localparam int GRAV  = 16;
    localparam int FRAC  = 4;
    localparam int BSH   = 1;
    localparam int VREST = 16;
    localparam int VMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ml;
    logic [11:0] mx, my;
    logic [11:0] xpos, ypos;
    logic [1:0]  phys_state;

    always #5 clk = ~clk;

    draw_rect_phys_ctl #(.TICK_DIV(TD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mouse_left       (ml),
        .mouse_x_position (mx),
        .mouse_y_position (my),
        .xpos             (xpos),
        .ypos             (ypos),
        .phys_state       (phys_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // behavioural model: 0=FOLLOW 1=FALL 2=RISE 3=REST, cycles counted since the last reload
    int m_state, m_x, m_y, m_vel, m_since, m_mlq;

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_vel = 0; m_since = 0; m_mlq = 0;
    endtask

    task automatic model_step(input int x, input int y, input int l);
        int click, tick, step, d;
        click = (l != 0) && (m_mlq == 0);
        m_mlq = l;
        tick  = !click && (m_since == TD - 1);
        m_since = (click || m_since == TD - 1) ? 0 : m_since + 1;
        if (m_state == 0) begin
            m_x = (x > XMAX) ? XMAX : x;
            m_y = (y > FLOOR) ? FLOOR : y;
            if (click) begin m_state = 1; m_vel = 0; end
        end else if (click) begin
            m_state = 0; m_vel = 0;
        end else if (tick) begin
            step = m_vel / (1 << FRAC);
            if (m_state == 1) begin
                if (m_y + step >= FLOOR) begin
                    m_y = FLOOR;
                    d = m_vel / (1 << BSH);
                    if (d < VREST) begin m_state = 3; m_vel = 0; end
                    else begin m_state = 2; m_vel = d; end
                end else begin
                    m_y   = m_y + step;
                    m_vel = (m_vel + GRAV > VMAX) ? VMAX : m_vel + GRAV;
                end
            end else if (m_state == 2) begin
                m_y = (m_y - step < 0) ? 0 : m_y - step;
                if (m_vel <= GRAV) begin m_state = 1; m_vel = 0; end
                else m_vel = m_vel - GRAV;
            end
        end
    endtask

    task automatic cyc(input int x, input int y, input int l);
        mx = 12'(x); my = 12'(y); ml = (l != 0);
        @(posedge clk);
        model_step(x, y, l);
        #1;
        check("model_x", 32'(xpos), 32'(m_x));
        check("model_y", 32'(ypos), 32'(m_y));
        check("model_state", 32'(phys_state), 32'(m_state));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int exp_y [7] = '{526, 527, 529, 532, 536, 534, 533};
        int exp_s [7] = '{1, 1, 1, 1, 2, 2, 1};
        int x, y, l;

        rst_n = 1'b0; mx = '0; my = '0; ml = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", 32'(xpos), 0);
        check("rst_y", 32'(ypos), 0);
        check("rst_state", 32'(phys_state), 0);
        rst_n = 1'b1;

        cyc(900, 700, 0);
        check("clamp_x", 32'(xpos), 752);
        check("clamp_y", 32'(ypos), 536);
        cyc(100, 200, 0);
        check("follow_x", 32'(xpos), 100);
        check("follow_y", 32'(ypos), 200);

        // drop from 526 with the button held throughout the fall
        cyc(300, 526, 1);
        check("drop_state", 32'(phys_state), 1);
        check("drop_y", 32'(ypos), 526);
        for (int k = 0; k < 7; k++) begin
            repeat (TD) cyc(300, 526, 1);
            check("fall_y", 32'(ypos), 32'(exp_y[k]));
            check("fall_state", 32'(phys_state), 32'(exp_s[k]));
        end
        repeat (TD * 8) cyc(300, 526, 0);
        check("settle_state", 32'(phys_state), 3);
        check("settle_y", 32'(ypos), 536);
        check("settle_x", 32'(xpos), 300);

        // re-grab from REST, then a held button stays in FOLLOW
        cyc(50, 60, 1);
        check("regrab_state", 32'(phys_state), 0);
        cyc(50, 60, 1);
        check("hold_state", 32'(phys_state), 0);
        check("hold_x", 32'(xpos), 50);
        check("hold_y", 32'(ypos), 60);

        // drop right at the floor
        cyc(50, 600, 0);
        cyc(50, 600, 1);
        check("floor_drop_y", 32'(ypos), 536);
        repeat (TD) cyc(50, 600, 0);
        check("floor_rest_state", 32'(phys_state), 3);
        check("floor_rest_y", 32'(ypos), 536);

        // re-grab while rising
        cyc(0, 0, 1);
        cyc(200, 526, 0);
        cyc(200, 526, 1);
        repeat (5 * TD) cyc(200, 526, 0);
        check("rise_state", 32'(phys_state), 2);
        cyc(300, 100, 1);
        check("rise_regrab_state", 32'(phys_state), 0);
        repeat (3) cyc(300, 100, 1);
        check("rise_hold_state", 32'(phys_state), 0);
        check("rise_hold_x", 32'(xpos), 300);
        check("rise_hold_y", 32'(ypos), 100);

        // asynchronous reset between edges while falling
        cyc(300, 100, 0);
        cyc(300, 100, 1);
        repeat (10) cyc(300, 100, 0);
        check("pre_reset_state", 32'(phys_state), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_x", 32'(xpos), 0);
        check("async_y", 32'(ypos), 0);
        check("async_state", 32'(phys_state), 0);
        model_reset();
        @(posedge clk);
        #1;
        check("async_hold_state", 32'(phys_state), 0);
        rst_n = 1'b1;

        x = 100; y = 100; l = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) begin
                x = $urandom_range(0, 1000);
                y = ($urandom % 4 == 0) ? $urandom_range(500, 700) : $urandom_range(0, 700);
            end
            if ($urandom % 30 == 0) l = (l == 0);
            cyc(x, y, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
